// File: rtl/conv_mac_pkg.sv
// Shared definitions for the convolution multiply-accumulate pipeline.
//   MAC_MAX_STAGES   : deepest supported multiplier pipeline
//   MAC_*            : default operand/accumulator widths and depth
//   prod_width()     : width of the full signed product of two extended operands
//   beat_side_t      : valid/first/last sideband that travels with each beat
package conv_mac_pkg;

    localparam int MAC_MAX_STAGES = 6;
    localparam int MAC_DIN0_WIDTH = 32;
    localparam int MAC_DIN1_WIDTH = 32;
    localparam int MAC_ACC_WIDTH  = 72;
    localparam int MAC_MUL_STAGES = 3;

    // Each operand grows by one extension bit, so the signed product needs
    // (w0 + 1) + (w1 + 1) bits to hold every possible result.
    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 2;
    endfunction

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_side_t;

endpackage

// File: rtl/conv_mac_pipe_mul.sv
// conv_mul_pipe: operand extension, signed multiply and MUL_STAGES pipeline
// registers (one input register plus MUL_STAGES-1 product registers), all
// advancing together under en. The beat sideband moves in lockstep.
//   clk, reset_n : clock, asynchronous active-low reset (clears sideband)
//   en           : pipeline advance
//   in_side      : valid/first/last of the incoming beat
//   din0, din1   : raw operands
//   out_side     : sideband aligned with product
//   product      : full-width signed product
module conv_mul_pipe
    import conv_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = MAC_DIN0_WIDTH,
    parameter int DIN1_WIDTH = MAC_DIN1_WIDTH,
    parameter int MUL_STAGES = MAC_MUL_STAGES,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0,
    localparam int PROD_WIDTH = prod_width(DIN0_WIDTH, DIN1_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  beat_side_t            in_side,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output beat_side_t            out_side,
    output logic [PROD_WIDTH-1:0] product
);

    logic                         ext0;
    logic                         ext1;
    logic [DIN0_WIDTH:0]          a_q;
    logic [DIN1_WIDTH:0]          b_q;
    logic signed [PROD_WIDTH-1:0] a_wide;
    logic signed [PROD_WIDTH-1:0] b_wide;
    logic signed [PROD_WIDTH-1:0] mul;
    beat_side_t                   side_q [MUL_STAGES];

    // Extension bit: copy of the MSB for two's-complement operands, 0 otherwise.
    assign ext0 = (SIGNED0 != 0) && din0[DIN0_WIDTH-1];
    assign ext1 = (SIGNED1 != 0) && din1[DIN1_WIDTH-1];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's old value on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < MUL_STAGES; k++) side_q[k] <= '0;
        end else if (en) begin
            side_q[0] <= in_side;
            for (int k = 1; k < MUL_STAGES; k++) side_q[k] <= side_q[k-1];
        end
    end

    // NOTE: operand/product data carry no reset; only the valid sideband has
    // to be cleared, and data behind a cleared valid is never consumed.
    always_ff @(posedge clk) begin
        if (en) begin
            a_q <= {ext0, din0};
            b_q <= {ext1, din1};
        end
    end

    assign a_wide = PROD_WIDTH'($signed(a_q));
    assign b_wide = PROD_WIDTH'($signed(b_q));
    assign mul    = a_wide * b_wide;

    generate
        if (MUL_STAGES == 1) begin : g_comb
            assign product = mul;
        end else begin : g_reg
            logic [PROD_WIDTH-1:0] prod_q [1:MUL_STAGES-1];

            always_ff @(posedge clk) begin
                if (en) begin
                    prod_q[1] <= mul;
                    for (int k = 2; k < MUL_STAGES; k++) prod_q[k] <= prod_q[k-1];
                end
            end

            assign product = prod_q[MUL_STAGES-1];
        end
    endgenerate

    assign out_side = side_q[MUL_STAGES-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined multiply-accumulate that sums one framed group of
// taps (in_first .. in_last) into a single result with valid/ready flow control.
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : input beat handshake (in_ready = pipeline advance)
//   din0, din1           : pixel and coefficient operands
//   in_first / in_last   : group framing carried with the beat
//   out_valid / out_ready: result handshake
//   dout                 : group sum, ACC_WIDTH wide
//   out_ovf              : sticky overflow seen while summing this group
module conv_mac_pipe
    import conv_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = MAC_DIN0_WIDTH,
    parameter int DIN1_WIDTH = MAC_DIN1_WIDTH,
    parameter int ACC_WIDTH  = MAC_ACC_WIDTH,
    parameter int MUL_STAGES = MAC_MUL_STAGES,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  out_ovf
);

    localparam int  PW         = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam bit  SIGNED_ANY = (SIGNED0 != 0) || (SIGNED1 != 0);

    logic                 adv;
    beat_side_t           in_side;
    beat_side_t           p_side;
    logic [PW-1:0]        product;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic [ACC_WIDTH:0]   sum_w;
    logic                 ovf_q;
    logic                 ovf_nxt;
    logic                 add_ovf;
    logic                 p_take;
    logic                 load_out;

    // The whole pipeline freezes only while a finished result waits for the
    // consumer; otherwise every stage moves each cycle.
    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;
    assign in_side  = '{valid: in_valid, first: in_first, last: in_last};

    conv_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .MUL_STAGES (MUL_STAGES),
        .SIGNED0    (SIGNED0),
        .SIGNED1    (SIGNED1)
    ) u_mul (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (adv),
        .in_side  (in_side),
        .din0     (din0),
        .din1     (din1),
        .out_side (p_side),
        .product  (product)
    );

    // Sign-extend (or drop redundant top bits when ACC_WIDTH < PW; those bits
    // are pure extension for any legal ACC_WIDTH).
    assign prod_ext = ACC_WIDTH'($signed(product));

    // NOTE: each signal is assigned on every path through this block so no
    // latch is inferred.
    always_comb begin
        sum_w   = {1'b0, acc_q} + {1'b0, prod_ext};
        add_ovf = 1'b0;
        if (SIGNED_ANY) begin
            add_ovf = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (sum_w[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum_w[ACC_WIDTH];
        end
        acc_nxt = p_side.first ? prod_ext : sum_w[ACC_WIDTH-1:0];
        ovf_nxt = p_side.first ? 1'b0     : (ovf_q | add_ovf);
    end

    assign p_take   = adv & p_side.valid;
    assign load_out = p_take & p_side.last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            dout      <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (p_take) begin
                acc_q <= acc_nxt;
                ovf_q <= ovf_nxt;
            end
            // A new result may land in the same cycle the old one is taken.
            if (load_out) begin
                dout      <= acc_nxt;
                out_ovf   <= ovf_nxt;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Testbench for conv_mac_pipe: five parameterisations share one stimulus bus;
// sel picks which instance the driver handshakes with and the monitor records.
module tb_conv_mac_pipe;

    localparam int S_DEF = 0;
    localparam int S_S1  = 1;
    localparam int S_W65 = 2;
    localparam int S_M1  = 3;
    localparam int S_M6  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        in_first;
    logic        in_last;
    logic        out_ready;

    logic        rdy_def, ov_def, ovf_def;
    logic [71:0] dout_def;
    logic        rdy_s1, ov_s1, ovf_s1;
    logic [71:0] dout_s1;
    logic        rdy_w65, ov_w65, ovf_w65;
    logic [64:0] dout_w65;
    logic        rdy_m1, ov_m1, ovf_m1;
    logic [71:0] dout_m1;
    logic        rdy_m6, ov_m6, ovf_m6;
    logic [71:0] dout_m6;

    int          sel;
    logic        cur_rdy, cur_ov, cur_ovf;
    logic [71:0] cur_dout;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          last_acc_cyc = 0;
    bit          rnd_on = 1'b0;

    logic [71:0] rx_dout [$];
    logic        rx_ovf  [$];
    int          rx_cyc  [$];

    always #5 clk = ~clk;

    conv_mac_pipe u_def (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_def),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(ov_def), .out_ready(out_ready), .dout(dout_def), .out_ovf(ovf_def));

    conv_mac_pipe #(.SIGNED1(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_s1),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(ov_s1), .out_ready(out_ready), .dout(dout_s1), .out_ovf(ovf_s1));

    conv_mac_pipe #(.ACC_WIDTH(65)) u_w65 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_w65),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(ov_w65), .out_ready(out_ready), .dout(dout_w65), .out_ovf(ovf_w65));

    conv_mac_pipe #(.MUL_STAGES(1)) u_m1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_m1),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(ov_m1), .out_ready(out_ready), .dout(dout_m1), .out_ovf(ovf_m1));

    conv_mac_pipe #(.MUL_STAGES(6)) u_m6 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_m6),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(ov_m6), .out_ready(out_ready), .dout(dout_m6), .out_ovf(ovf_m6));

    always_comb begin
        cur_rdy  = rdy_def;
        cur_ov   = ov_def;
        cur_ovf  = ovf_def;
        cur_dout = dout_def;
        case (sel)
            S_S1:  begin cur_rdy = rdy_s1;  cur_ov = ov_s1;  cur_ovf = ovf_s1;  cur_dout = dout_s1; end
            S_W65: begin cur_rdy = rdy_w65; cur_ov = ov_w65; cur_ovf = ovf_w65; cur_dout = {7'b0, dout_w65}; end
            S_M1:  begin cur_rdy = rdy_m1;  cur_ov = ov_m1;  cur_ovf = ovf_m1;  cur_dout = dout_m1; end
            S_M6:  begin cur_rdy = rdy_m6;  cur_ov = ov_m6;  cur_ovf = ovf_m6;  cur_dout = dout_m6; end
            default: ;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    // A transfer happens on the next rising edge when valid & ready are seen here.
    always @(negedge clk) begin
        if (reset_n && cur_ov && out_ready) begin
            rx_dout.push_back(cur_dout);
            rx_ovf.push_back(cur_ovf);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference product: exact arithmetic on the operands' numeric values.
    function automatic logic [79:0] prod80(input logic [31:0] a, input logic [31:0] b, input bit s1);
        logic signed [79:0] x;
        logic signed [79:0] y;
        x = {48'b0, a};
        y = s1 ? {{48{b[31]}}, b} : {48'b0, b};
        return x * y;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit f, input bit l);
        bit ok;
        in_valid = 1'b1;
        din0     = a;
        din1     = b;
        in_first = f;
        in_last  = l;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            ok = cur_rdy;
            last_acc_cyc = cyc;
            step();
            if (ok) break;
        end
        if (!ok) check("send_timeout", {79'b0, ok}, 80'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rx_dout.size() < n && t < budget) begin
            step();
            t++;
        end
        if (rx_dout.size() < n) check("rx_timeout", rx_dout.size(), n);
    endtask

    task automatic clear_rx();
        rx_dout.delete();
        rx_ovf.delete();
        rx_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        clear_rx();
    endtask

    task automatic run_random(input bit s1, input int ngroups, input string tag);
        logic [71:0] exp_d [$];
        logic        exp_o [$];
        logic [79:0] exact;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        clear_rx();
        rnd_on = 1'b1;
        for (int g = 0; g < ngroups; g++) begin
            // Occasionally open a group and abandon it: it must vanish silently.
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) send($urandom, $urandom, i == 0, 1'b0);
            end
            n = $urandom_range(1, 9);
            exact = '0;
            for (int i = 0; i < n; i++) begin
                a = $urandom;
                b = $urandom;
                exact = exact + prod80(a, b, s1);
                send(a, b, i == 0, i == n - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            exp_d.push_back(exact[71:0]);
            if (s1) exp_o.push_back((exact[79:71] != '0) && (exact[79:71] != '1));
            else    exp_o.push_back(exact[79:72] != '0);
        end
        rnd_on    = 1'b0;
        out_ready = 1'b1;
        wait_rx(exp_d.size(), 2000);
        idle(10);
        check({tag, "_count"}, rx_dout.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < rx_dout.size(); i++) begin
            check($sformatf("%s_dout%0d", tag, i), {8'b0, rx_dout[i]}, {8'b0, exp_d[i]});
            check($sformatf("%s_ovf%0d", tag, i), {79'b0, rx_ovf[i]}, {79'b0, exp_o[i]});
        end
    endtask

    initial begin
        logic [79:0] big;
        int          t;

        sel = S_DEF; reset_n = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        idle(3);

        // Reset state of every instance.
        for (int s = S_DEF; s <= S_M6; s++) begin
            sel = s;
            #1;
            check($sformatf("rst_valid%0d", s), {79'b0, cur_ov},  80'd0);
            check($sformatf("rst_dout%0d", s),  {8'b0, cur_dout}, 80'd0);
            check($sformatf("rst_ovf%0d", s),   {79'b0, cur_ovf}, 80'd0);
            check($sformatf("rst_ready%0d", s), {79'b0, cur_rdy}, 80'd1);
        end
        sel = S_DEF;
        reset_n = 1'b1;
        step();

        // 9 unsigned taps 1..9 times 2.
        do_reset();
        for (int i = 1; i <= 9; i++) send(i, 2, i == 1, i == 9);
        wait_rx(1, 50);
        check("sum9_dout", {8'b0, rx_dout[0]}, 80'd90);
        check("sum9_ovf", {79'b0, rx_ovf[0]}, 80'd0);
        check("sum9_latency", rx_cyc[0] - last_acc_cyc, 80'd4);

        // Signed coefficients.
        sel = S_S1;
        do_reset();
        send(100, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(50,  32'd3,         1'b0, 1'b0);
        send(7,   32'hFFFF_FFF9, 1'b0, 1'b1);
        wait_rx(1, 50);
        check("signed_dout", {8'b0, rx_dout[0]}, 80'd1);
        @(negedge clk);
        check("signed_one_cycle", {79'b0, cur_ov}, 80'd0);
        step();

        // Back-to-back groups with a 5-cycle output stall.
        sel = S_DEF;
        do_reset();
        fork
            begin
                send(1, 1, 1'b1, 1'b0); send(2, 2, 1'b0, 1'b0); send(3, 3, 1'b0, 1'b1);
                send(4, 4, 1'b1, 1'b0); send(5, 5, 1'b0, 1'b0); send(6, 6, 1'b0, 1'b1);
            end
            begin
                t = 0;
                while (!cur_ov && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                out_ready = 1'b0;
                @(negedge clk);
                check("stall_in_ready", {79'b0, cur_rdy}, 80'd0);
                check("stall_dout", {8'b0, cur_dout}, 80'd14);
                repeat (4) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("stall_hold", {7'b0, cur_ov, cur_dout}, {7'b0, 1'b1, 72'd14});
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_rx(2, 50);
        idle(8);
        check("b2b_count", rx_dout.size(), 80'd2);
        check("b2b_first", {8'b0, rx_dout[0]}, 80'd14);
        check("b2b_second", {8'b0, rx_dout[1]}, 80'd77);

        // Unsigned overflow at ACC_WIDTH = 65, then a clean group.
        sel = S_W65;
        do_reset();
        for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, i == 0, i == 3);
        send(1, 1, 1'b1, 1'b1);
        wait_rx(2, 50);
        big = 4 * prod80(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("w65_dout", {8'b0, rx_dout[0]}, big & ((80'd1 << 65) - 80'd1));
        check("w65_ovf", {79'b0, rx_ovf[0]}, {79'b0, |big[79:65]});
        check("w65_next_dout", {8'b0, rx_dout[1]}, 80'd1);
        check("w65_next_ovf", {79'b0, rx_ovf[1]}, 80'd0);

        // Reset mid-group discards everything in flight.
        sel = S_DEF;
        do_reset();
        for (int i = 1; i <= 4; i++) send(i, 9, i == 1, 1'b0);
        reset_n = 1'b0;
        step();
        check("midrst_valid", {79'b0, cur_ov}, 80'd0);
        step();
        reset_n = 1'b1;
        step();
        send(3, 4, 1'b1, 1'b0);
        send(5, 6, 1'b0, 1'b1);
        wait_rx(1, 50);
        idle(10);
        check("midrst_count", rx_dout.size(), 80'd1);
        check("midrst_dout", {8'b0, rx_dout[0]}, 80'd42);

        // No first after reset: accumulation starts from zero.
        do_reset();
        send(2, 3, 1'b0, 1'b1);
        wait_rx(1, 50);
        check("nofirst_dout", {8'b0, rx_dout[0]}, 80'd6);

        // Multiplier depth sweep.
        sel = S_M1;
        do_reset();
        send(7, 6, 1'b1, 1'b1);
        wait_rx(1, 50);
        check("m1_dout", {8'b0, rx_dout[0]}, 80'd42);
        check("m1_latency", rx_cyc[0] - last_acc_cyc, 80'd2);
        sel = S_M6;
        do_reset();
        send(7, 6, 1'b1, 1'b1);
        wait_rx(1, 50);
        check("m6_dout", {8'b0, rx_dout[0]}, 80'd42);
        check("m6_latency", rx_cyc[0] - last_acc_cyc, 80'd7);

        // Randomised groups with random gaps and backpressure.
        sel = S_DEF;
        do_reset();
        run_random(1'b0, 25, "rnd_u");
        sel = S_S1;
        do_reset();
        run_random(1'b1, 25, "rnd_s");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
